// File: rtl/tile_pkg.sv
// Shared tile constants and types for the game manager and the tile renderer.
package tile_pkg;

   localparam logic [4:0]  TILE_DARK     = 5'd31;
   localparam logic [4:0]  TILE_LAST_LIT = 5'd18;
   localparam int unsigned TILE_PX       = 16;
   localparam int unsigned ROW_W         = 40;
   localparam int unsigned TILES_PER_ROW = 8;

   // Index bases of each tile family
   localparam logic [4:0] DIGIT0  = 5'd0;
   localparam logic [4:0] PLAYER0 = 5'd10;
   localparam logic [4:0] BULLET0 = 5'd13;
   localparam logic [4:0] BUBBLE0 = 5'd16;

   localparam int unsigned ROM_AW = 13;
   localparam int unsigned ROM_DW = 12;

   typedef logic [ROW_W-1:0] row_t;

   // Tile ROM address: tile index, texel row, texel column
   typedef struct packed {
      logic [4:0] idx;
      logic [3:0] ty;
      logic [3:0] tx;
   } tex_addr_t;

   // Column 0 sits in the top five bits of a row
   function automatic logic [4:0] row_idx(input row_t row, input logic [2:0] col);
      row_t shifted;
      shifted = row << (5 * col);
      return shifted[ROW_W-1 -: 5];
   endfunction

endpackage

// File: rtl/tile_renderer_if.sv
// Pixel-coordinate in / colour out bundle between VGA timing and the renderer.
interface tile_renderer_if;

   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        active;
   logic [11:0] pixel;
   logic        pixel_valid;

   modport master (
      output h_cnt,
      output v_cnt,
      output active,
      input  pixel,
      input  pixel_valid
   );

   modport slave (
      input  h_cnt,
      input  v_cnt,
      input  active,
      output pixel,
      output pixel_valid
   );

endinterface

// File: rtl/tile_rom.sv
// 8192x12 texel ROM with a registered read port; infers block RAM.
module tile_rom
  import tile_pkg::*;
#(
  parameter string ROM_FILE = "tiles.mem"
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [ROM_DW-1:0] data
);

  // Contents are supplied by the surrounding environment
  logic [ROM_DW-1:0] mem [0:(1 << ROM_AW) - 1];

  // Synchronous read, no reset so it maps onto a RAM primitive
  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/tile_renderer.sv
// Two-stage tile renderer: snapshots the eight board rows once per frame, maps
// each pixel coordinate to a tile texel and emits its RGB444 colour.
module tile_renderer
   import tile_pkg::*;
#(
   parameter int unsigned SCALE_LOG2 = 1,
   parameter int unsigned ORIGIN_X   = 192,
   parameter int unsigned ORIGIN_Y   = 112,
   parameter logic [11:0] BG_COLOR   = 12'h000,
   parameter string       ROM_FILE   = "tiles.mem"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic [ROW_W-1:0] Row1,
   input  logic [ROW_W-1:0] Row2,
   input  logic [ROW_W-1:0] Row3,
   input  logic [ROW_W-1:0] Row4,
   input  logic [ROW_W-1:0] Row5,
   input  logic [ROW_W-1:0] Row6,
   input  logic [ROW_W-1:0] Row7,
   input  logic [ROW_W-1:0] Row8,
   tile_renderer_if.slave   vid
);

   localparam int unsigned BOARD     = TILES_PER_ROW * TILE_PX * (1 << SCALE_LOG2);
   localparam int unsigned COL_SHIFT = $clog2(TILE_PX) + SCALE_LOG2;

   // 11-bit bounds so the board end never wraps against a 10-bit counter
   localparam logic [10:0] X_LO = 11'(ORIGIN_X);
   localparam logic [10:0] X_HI = 11'(ORIGIN_X + BOARD);
   localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
   localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + BOARD);
   localparam logic [9:0]  OX   = 10'(ORIGIN_X);
   localparam logic [9:0]  OY   = 10'(ORIGIN_Y);

   localparam row_t DARK_ROW = {TILES_PER_ROW{TILE_DARK}};

   // Index 0 holds Row1 (top of board)
   logic [TILES_PER_ROW-1:0][ROW_W-1:0] shadow_q;

   logic        inside_d;
   logic [10:0] h_ext;
   logic [10:0] v_ext;
   logic [9:0]  dx;
   logic [9:0]  dy;
   logic [2:0]  col;
   logic [2:0]  row;
   tex_addr_t   tex_d;

   logic        active_q1;
   logic        inside_q1;
   tex_addr_t   tex_q1;

   logic        active_q2;
   logic        inside_q2;
   logic        dark_q2;
   logic [11:0] rom_data;

   // Per-frame snapshot so the board never changes mid-frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= {TILES_PER_ROW{DARK_ROW}};
      end else if (frame_start) begin
         shadow_q <= {Row8, Row7, Row6, Row5, Row4, Row3, Row2, Row1};
      end
   end

   // Coordinate to tile/texel mapping; bounds are checked before the subtraction
   always_comb begin
      h_ext    = {1'b0, vid.h_cnt};
      v_ext    = {1'b0, vid.v_cnt};
      inside_d = vid.active && (h_ext >= X_LO) && (h_ext < X_HI)
                 && (v_ext >= Y_LO) && (v_ext < Y_HI);
      dx       = vid.h_cnt - OX;
      dy       = vid.v_cnt - OY;
      col      = 3'(dx >> COL_SHIFT);
      row      = 3'(dy >> COL_SHIFT);
      tex_d.tx  = 4'(dx >> SCALE_LOG2);
      tex_d.ty  = 4'(dy >> SCALE_LOG2);
      tex_d.idx = row_idx(shadow_q[row], col);
   end

   // Stage 1: flags and texel address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q1 <= 1'b0;
         inside_q1 <= 1'b0;
         tex_q1    <= '0;
      end else begin
         active_q1 <= vid.active;
         inside_q1 <= inside_d;
         tex_q1    <= tex_d;
      end
   end

   tile_rom #(
      .ROM_FILE (ROM_FILE)
   ) u_rom (
      .clk  (clk),
      .addr (tex_q1),
      .data (rom_data)
   );

   // Stage 2: flags travelling alongside the ROM read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q2 <= 1'b0;
         inside_q2 <= 1'b0;
         dark_q2   <= 1'b0;
      end else begin
         active_q2 <= active_q1;
         inside_q2 <= inside_q1;
         dark_q2   <= (tex_q1.idx > TILE_LAST_LIT);
      end
   end

   // Output mux; gated by reset-cleared flags so reset blanks the output at once
   always_comb begin
      vid.pixel       = 12'h000;
      vid.pixel_valid = active_q2;
      if (active_q2) begin
         if (!inside_q2) begin
            vid.pixel = BG_COLOR;
         end else if (dark_q2) begin
            vid.pixel = 12'h000;
         end else begin
            vid.pixel = rom_data;
         end
      end
   end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: vector tables plus hand-timed sequences.
module tb_tile_renderer;

   localparam logic [11:0] BG = 12'h3C5;

   typedef struct packed {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        act;
      logic [11:0] px;
      logic        vld;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic [39:0] row1, row2, row3, row4, row5, row6, row7, row8;

   int checks = 0;
   int errors = 0;

   vec_t tbl_a [6];
   vec_t tbl_b [15];

   tile_renderer_if vid ();

   tile_renderer #(
      .SCALE_LOG2 (1),
      .ORIGIN_X   (192),
      .ORIGIN_Y   (112),
      .BG_COLOR   (BG),
      .ROM_FILE   ("")
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .Row1        (row1),
      .Row2        (row2),
      .Row3        (row3),
      .Row4        (row4),
      .Row5        (row5),
      .Row6        (row6),
      .Row7        (row7),
      .Row8        (row8),
      .vid         (vid)
   );

   always #5 clk = ~clk;

   // Texel image loaded into the ROM; nonzero at every address used below
   function automatic logic [11:0] rom_model(input logic [12:0] a);
      return a[11:0] ^ {a[12], 11'b0} ^ 12'h5A3;
   endfunction

   task automatic chk(input string nm, input logic [11:0] exp_px, input logic exp_v);
      checks++;
      if (vid.pixel !== exp_px || vid.pixel_valid !== exp_v) begin
         errors++;
         $display("FAIL %s: got pixel=%h valid=%b, expected pixel=%h valid=%b",
                  nm, vid.pixel, vid.pixel_valid, exp_px, exp_v);
      end
   endtask

   task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic act);
      vid.h_cnt  = h;
      vid.v_cnt  = v;
      vid.active = act;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold one coordinate for two edges, then compare the settled output
   task automatic run_vec(input vec_t t, input string nm);
      drive(t.h, t.v, t.act);
      tick();
      tick();
      chk(nm, t.px, t.vld);
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      logic [16:0] pat;

      for (int a = 0; a < 8192; a++) dut.u_rom.mem[a] = rom_model(13'(a));

      // Rows present but never snapshotted: board must stay dark
      row1 = {8{5'd1}}; row2 = {8{5'd1}}; row3 = {8{5'd1}}; row4 = {8{5'd1}};
      row5 = {8{5'd1}}; row6 = {8{5'd1}}; row7 = {8{5'd1}}; row8 = {8{5'd1}};
      drive(10'd192, 10'd112, 1'b1);

      tbl_a[0] = '{10'd192, 10'd112, 1'b1, 12'h000, 1'b1};
      tbl_a[1] = '{10'd447, 10'd367, 1'b1, 12'h000, 1'b1};
      tbl_a[2] = '{10'd300, 10'd200, 1'b1, 12'h000, 1'b1};
      tbl_a[3] = '{10'd191, 10'd112, 1'b1, BG,      1'b1};
      tbl_a[4] = '{10'd100, 10'd50,  1'b1, BG,      1'b1};
      tbl_a[5] = '{10'd300, 10'd200, 1'b0, 12'h000, 1'b0};

      tbl_b[0]  = '{10'd192, 10'd112, 1'b1, rom_model(13'h100), 1'b1};
      tbl_b[1]  = '{10'd223, 10'd143, 1'b1, rom_model(13'h1FF), 1'b1};
      tbl_b[2]  = '{10'd224, 10'd112, 1'b1, 12'h000,            1'b1};
      tbl_b[3]  = '{10'd194, 10'd114, 1'b1, rom_model(13'h111), 1'b1};
      tbl_b[4]  = '{10'd447, 10'd367, 1'b1, rom_model(13'hAFF), 1'b1};
      tbl_b[5]  = '{10'd448, 10'd367, 1'b1, BG,                 1'b1};
      tbl_b[6]  = '{10'd447, 10'd368, 1'b1, BG,                 1'b1};
      tbl_b[7]  = '{10'd192, 10'd111, 1'b1, BG,                 1'b1};
      tbl_b[8]  = '{10'd191, 10'd200, 1'b1, BG,                 1'b1};
      tbl_b[9]  = '{10'd192, 10'd176, 1'b1, 12'h000,            1'b1};
      tbl_b[10] = '{10'd192, 10'd208, 1'b1, rom_model(13'h1200), 1'b1};
      tbl_b[11] = '{10'd224, 10'd208, 1'b1, 12'h000,            1'b1};
      tbl_b[12] = '{10'd400, 10'd300, 1'b1, 12'h000,            1'b1};
      tbl_b[13] = '{10'd200, 10'd112, 1'b0, 12'h000,            1'b0};
      tbl_b[14] = '{10'd224, 10'd112, 1'b0, 12'h000,            1'b0};

      // Reset state
      tick();
      tick();
      chk("reset_hold", 12'h000, 1'b0);
      rst = 1'b0;
      tick();
      chk("first_edge_after_reset", 12'h000, 1'b0);

      for (int i = 0; i < 6; i++) run_vec(tbl_a[i], $sformatf("pre_frame_%0d", i));

      // pixel_valid tracks active two cycles late
      pat = 17'b0_1011_0011_1000_1101;
      for (int i = 0; i < 17; i++) begin
         drive(10'(100 + i), 10'd50, pat[i]);
         tick();
         if (i >= 1) chk($sformatf("valid_stream_%0d", i), pat[i-1] ? BG : 12'h000, pat[i-1]);
      end

      // Load a known board
      row1 = {5'd1, {7{5'd31}}};
      row2 = {8{5'd31}};
      row3 = {5'd20, {7{5'd31}}};
      row4 = {5'd18, 5'd19, {6{5'd31}}};
      row5 = {8{5'd31}};
      row6 = {8{5'd31}};
      row7 = {8{5'd31}};
      row8 = {{7{5'd31}}, 5'd10};
      drive(10'd0, 10'd0, 1'b0);
      pulse_frame();

      for (int i = 0; i < 15; i++) run_vec(tbl_b[i], $sformatf("board_%0d", i));

      // Row change without frame_start has no effect
      row2 = {5'd2, {7{5'd31}}};
      run_vec('{10'd192, 10'd144, 1'b1, 12'h000, 1'b1}, "row2_no_snapshot");

      // frame_start mid-line: same-cycle pixel old, next-cycle pixel new
      drive(10'd192, 10'd144, 1'b1);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      drive(10'd193, 10'd144, 1'b1);
      tick();
      chk("fs_same_cycle_old", 12'h000, 1'b1);
      drive(10'd0, 10'd0, 1'b0);
      tick();
      chk("fs_next_cycle_new", rom_model(13'h200), 1'b1);

      // Asynchronous reset mid-board
      run_vec('{10'd192, 10'd112, 1'b1, rom_model(13'h100), 1'b1}, "pre_reset_lit");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_reset_immediate", 12'h000, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_reset_edge1", 12'h000, 1'b0);
      tick();
      chk("post_reset_dark", 12'h000, 1'b1);
      run_vec('{10'd447, 10'd367, 1'b1, 12'h000, 1'b1}, "post_reset_dark_corner");
      pulse_frame();
      run_vec('{10'd192, 10'd112, 1'b1, rom_model(13'h100), 1'b1}, "post_reset_reload");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
